id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Parametrised ID→EX pipeline stage; successor to the fixed-width bare-flop ID/EX register.
- Adds a valid/ready handshake, a hazard hold and a branch/jump flush.
- Adds an optional one-entry skid buffer, so `in_ready` is registered and never combinationally depends on `out_ready`.
- Sits between the decoder and the execute unit; a downstream "invalid" output always looks like a NOP instruction.

Parameters:
- DW, 32: instruction, op1 and op2 width.
- AW, 32: instruction-address width.
- RAW, 5: destination register address width.
- NOP_INST, 32'h00000013: instruction value presented when the stage holds no valid entry.
- SKID, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID presents a decoded instruction.
- in_ready  out  1  stage can accept this cycle.
- inst_i  in  DW  instruction.
- inst_addr_i  in  AW  instruction address.
- op1_i  in  DW  operand 1.
- op2_i  in  DW  operand 2.
- rd_addr_i  in  RAW  destination register.
- reg_wen_i  in  1  register write enable.
- hold_i  in  1  hazard stall from control; freezes the output entry.
- flush_i  in  1  synchronous flush from branch/jump resolution.
- out_valid  out  1  EX entry valid.
- out_ready  in  1  EX consumes the entry this cycle.
- inst_o  out  DW  instruction to EX.
- inst_addr_o  out  AW  address to EX.
- op1_o  out  DW  operand 1 to EX.
- op2_o  out  DW  operand 2 to EX.
- rd_addr_o  out  RAW  destination register to EX.
- reg_wen_o  out  1  write enable to EX.
- skid_full_o  out  1  skid entry occupied; tied to 0 when SKID=0.

Behaviour:
- **Reset** (rst=0, asynchronous): out_valid=0, skid_full_o=0.
  - inst_o=NOP_INST; inst_addr_o, op1_o, op2_o, rd_addr_o = 0; reg_wen_o=0.
  - in_ready=1 after reset release.
  - Reset mid-transfer discards all entries.
- **Event definitions:**
  - Accept: in_valid & in_ready.
  - Drain: out_valid & out_ready & !hold_i.
  - hold_i=1 behaves as out_ready=0 for the output entry.
- **Invalid-output rule:** whenever out_valid=0, data outputs show NOP values (NOP_INST, zeros, reg_wen_o=0), never stale data.
- **Latency:** an entry accepted at edge N appears on the outputs after edge N (one cycle) when the main register is empty or draining that cycle.
- **SKID=1:**
  - in_ready = !skid_full, registered.
  - States are (main valid, skid full): EMPTY (0,0), ONE (1,0), FULL (1,1).
  - EMPTY + accept → ONE.
  - ONE + accept & drain → ONE, with new data in main.
  - ONE + accept & !drain → FULL, with new data in skid.
  - ONE + drain & !accept → EMPTY.
  - FULL + drain → ONE, skid moves to main; no accept possible since in_ready=0.
  - FULL + !drain → FULL, all held.
  - Ordering is strictly FIFO: skid data is never overtaken.
- **SKID=0:**
  - in_ready = !out_valid | (out_ready & !hold_i), combinational.
  - Single register; accept overwrites main.
- **Flush** (flush_i=1 at a rising edge), highest priority:
  - Clears main and skid.
  - out_valid=0, outputs go to NOP values, skid_full_o=0.
  - An entry offered the same cycle is consumed (handshake completes) but discarded.
  - Flush during hold: flush wins.
- **Simultaneous hold_i & out_ready:** no drain; the entry is held unchanged.
- Data is stored unmodified; there is no width conversion between ports.

Test Plan:
- Reset then single transfer: rst low→high; inst_i=32'h00500093, op1_i=5, rd_addr_i=1, reg_wen_i=1, in_valid=1 one cycle, out_ready=1 → next cycle out_valid=1, inst_o=32'h00500093, rd_addr_o=1, reg_wen_o=1; the following cycle out_valid=0, inst_o=32'h00000013, reg_wen_o=0.
- Back-pressure into skid (SKID=1): out_ready=0; send A=0x11, B=0x22 on consecutive cycles → out shows A, skid_full_o=1, in_ready=0; raise out_ready → out A, then B, then invalid; order preserved.
- Hold: entry C valid, out_ready=1, hold_i=1 for 3 cycles → out_valid=1, inst_o=C, unchanged for 3 cycles; it drains on the first cycle with hold_i=0.
- Flush with skid full plus a new offer: FULL state, in_valid offering D, flush_i=1 → next cycle out_valid=0, skid_full_o=0, inst_o=NOP_INST, in_ready=1; D never appears on the outputs.
- Async reset mid-stream: rst pulled low between clock edges while in FULL → outputs go to NOP values immediately, with no clock edge needed.
- SKID=0 streaming: in_valid=1 and out_ready=1 every cycle for 8 instructions → 8 consecutive valid outputs at one per cycle; in_ready=1 throughout.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_if
// Bundle of every handshake, control and payload signal of the ID->EX
// pipeline stage.
//   slave  : view taken by the pipeline stage itself.
//   master : view taken by the environment (decoder, control and EX side).
// Upstream   : in_valid, in_ready, inst_i, inst_addr_i, op1_i, op2_i,
//              rd_addr_i, reg_wen_i
// Control    : hold_i (hazard stall), flush_i (branch/jump flush)
// Downstream : out_valid, out_ready, inst_o, inst_addr_o, op1_o, op2_o,
//              rd_addr_o, reg_wen_o, skid_full_o
// -----------------------------------------------------------------------------
interface id_ex_pipe_if #(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int RAW = 5
) ();
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  inst_i;
   logic [AW-1:0]  inst_addr_i;
   logic [DW-1:0]  op1_i;
   logic [DW-1:0]  op2_i;
   logic [RAW-1:0] rd_addr_i;
   logic           reg_wen_i;
   logic           hold_i;
   logic           flush_i;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  inst_o;
   logic [AW-1:0]  inst_addr_o;
   logic [DW-1:0]  op1_o;
   logic [DW-1:0]  op2_o;
   logic [RAW-1:0] rd_addr_o;
   logic           reg_wen_o;
   logic           skid_full_o;

   modport slave (
      input  in_valid, inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
      input  hold_i, flush_i, out_ready,
      output in_ready, out_valid, inst_o, inst_addr_o, op1_o, op2_o,
      output rd_addr_o, reg_wen_o, skid_full_o
   );

   modport master (
      output in_valid, inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
      output hold_i, flush_i, out_ready,
      input  in_ready, out_valid, inst_o, inst_addr_o, op1_o, op2_o,
      input  rd_addr_o, reg_wen_o, skid_full_o
   );
endinterface

// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
// ID->EX pipeline stage with valid/ready handshake, hazard hold and
// branch/jump flush. With SKID=1 a second (skid) entry makes in_ready a
// pure register output; with SKID=0 a single register is used and in_ready
// is combinational.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : id_ex_pipe_if.slave (handshakes, hold/flush, payload in/out)
// While no valid entry is held the outputs show a NOP (NOP_INST, zeros).
// -----------------------------------------------------------------------------
module id_ex_pipe #(
   parameter int            DW       = 32,
   parameter int            AW       = 32,
   parameter int            RAW      = 5,
   parameter logic [DW-1:0] NOP_INST = DW'(32'h00000013),
   parameter bit            SKID     = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   id_ex_pipe_if.slave     bus
);
   // Payload packing order: inst, inst_addr, op1, op2, rd_addr, reg_wen
   localparam int PW = 3*DW + AW + RAW + 1;

   logic [PW-1:0] in_pl;
   logic [PW-1:0] nop_pl;
   logic [PW-1:0] out_pl;
   logic          main_valid_q;
   logic [PW-1:0] main_pl_q;
   logic          accept;
   logic          drain;

   assign in_pl  = {bus.inst_i, bus.inst_addr_i, bus.op1_i, bus.op2_i,
                    bus.rd_addr_i, bus.reg_wen_i};
   assign nop_pl = {NOP_INST, {(PW-DW){1'b0}}};

   assign accept = bus.in_valid & bus.in_ready;
   // hold_i masks out_ready: a held entry is never consumed
   assign drain  = main_valid_q & bus.out_ready & ~bus.hold_i;

   generate
      if (SKID) begin : g_skid
         logic          skid_valid_q;
         logic [PW-1:0] skid_pl_q;

         // in_ready is the inverse of a flop: no path from out_ready
         assign bus.in_ready    = ~skid_valid_q;
         assign bus.skid_full_o = skid_valid_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               main_valid_q <= 1'b0;
               main_pl_q    <= '0;
               skid_valid_q <= 1'b0;
               skid_pl_q    <= '0;
            end else if (bus.flush_i) begin
               // Any entry offered this cycle is handshaken but dropped
               main_valid_q <= 1'b0;
               skid_valid_q <= 1'b0;
            end else if (!main_valid_q || drain) begin
               // Main slot free this edge: refill from skid first (FIFO
               // order), otherwise from the input. A full skid implies
               // in_ready=0, so no accept can race with the skid move.
               if (skid_valid_q) begin
                  main_valid_q <= 1'b1;
                  main_pl_q    <= skid_pl_q;
                  skid_valid_q <= 1'b0;
               end else if (accept) begin
                  main_valid_q <= 1'b1;
                  main_pl_q    <= in_pl;
               end else begin
                  main_valid_q <= 1'b0;
               end
            end else if (accept) begin
               // Main is stalled: park the new entry in the skid slot
               skid_valid_q <= 1'b1;
               skid_pl_q    <= in_pl;
            end
         end
      end else begin : g_noskid
         assign bus.in_ready    = ~main_valid_q | drain;
         assign bus.skid_full_o = 1'b0;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               main_valid_q <= 1'b0;
               main_pl_q    <= '0;
            end else if (bus.flush_i) begin
               main_valid_q <= 1'b0;
            end else if (accept) begin
               main_valid_q <= 1'b1;
               main_pl_q    <= in_pl;
            end else if (drain) begin
               main_valid_q <= 1'b0;
            end
         end
      end
   endgenerate

   // Invalid entries are masked to NOP so EX never sees stale data; since
   // main_valid_q clears asynchronously, reset forces NOP without a clock.
   assign out_pl        = main_valid_q ? main_pl_q : nop_pl;
   assign bus.out_valid = main_valid_q;
   assign {bus.inst_o, bus.inst_addr_o, bus.op1_o, bus.op2_o,
           bus.rd_addr_o, bus.reg_wen_o} = out_pl;
endmodule

// File: tb/tb_id_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe
// Directed bench for id_ex_pipe: one instance with the skid buffer (u_skid)
// and one without (u_noskid). Inputs change 1 time unit after the rising
// edge; outputs are checked there as well.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    id_ex_pipe_if #(.DW(32), .AW(32), .RAW(5)) b1 ();
    id_ex_pipe_if #(.DW(32), .AW(32), .RAW(5)) b0 ();

    id_ex_pipe #(.DW(32), .AW(32), .RAW(5), .NOP_INST(NOP), .SKID(1'b1))
        u_skid (.clk(clk), .rst(rst), .bus(b1));
    id_ex_pipe #(.DW(32), .AW(32), .RAW(5), .NOP_INST(NOP), .SKID(1'b0))
        u_noskid (.clk(clk), .rst(rst), .bus(b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s value=%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.in_valid = 0; b1.inst_i = 0; b1.inst_addr_i = 0; b1.op1_i = 0;
        b1.op2_i = 0; b1.rd_addr_i = 0; b1.reg_wen_i = 0; b1.hold_i = 0;
        b1.flush_i = 0; b1.out_ready = 0;
        b0.in_valid = 0; b0.inst_i = 0; b0.inst_addr_i = 0; b0.op1_i = 0;
        b0.op2_i = 0; b0.rd_addr_i = 0; b0.reg_wen_i = 0; b0.hold_i = 0;
        b0.flush_i = 0; b0.out_ready = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        idle_inputs();
        #2;
        check("rst_out_valid", b1.out_valid, 1'b0);
        check("rst_inst", b1.inst_o, NOP);
        check("rst_addr", b1.inst_addr_o, 32'h0);
        check("rst_wen", b1.reg_wen_o, 1'b0);
        check("rst_skid", b1.skid_full_o, 1'b0);
        check("rst_ns_out_valid", b0.out_valid, 1'b0);
        tick(); tick();
        #2 rst = 1'b1;
        tick();
        check("rst_in_ready", b1.in_ready, 1'b1);

        b1.in_valid = 1; b1.inst_i = 32'h00500093; b1.op1_i = 32'd5;
        b1.rd_addr_i = 5'd1; b1.reg_wen_i = 1; b1.inst_addr_i = 32'h100;
        b1.out_ready = 1;
        tick();
        b1.in_valid = 0;
        check("x1_valid", b1.out_valid, 1'b1);
        check("x1_inst", b1.inst_o, 32'h00500093);
        check("x1_rd", b1.rd_addr_o, 5'd1);
        check("x1_wen", b1.reg_wen_o, 1'b1);
        check("x1_op1", b1.op1_o, 32'd5);
        check("x1_addr", b1.inst_addr_o, 32'h100);
        tick();
        check("x1_after_valid", b1.out_valid, 1'b0);
        check("x1_after_inst", b1.inst_o, NOP);
        check("x1_after_wen", b1.reg_wen_o, 1'b0);
        check("x1_after_op1", b1.op1_o, 32'd0);

        b1.out_ready = 0; b1.reg_wen_i = 0;
        b1.in_valid = 1; b1.inst_i = 32'h11;
        tick();
        b1.inst_i = 32'h22;
        check("bp_ready_one", b1.in_ready, 1'b1);
        tick();
        b1.in_valid = 0;
        check("bp_valid", b1.out_valid, 1'b1);
        check("bp_inst_a", b1.inst_o, 32'h11);
        check("bp_skid_full", b1.skid_full_o, 1'b1);
        check("bp_in_ready", b1.in_ready, 1'b0);
        tick();
        check("bp_held_a", b1.inst_o, 32'h11);
        b1.out_ready = 1;
        tick();
        check("bp_inst_b", b1.inst_o, 32'h22);
        check("bp_skid_empty", b1.skid_full_o, 1'b0);
        check("bp_ready_back", b1.in_ready, 1'b1);
        tick();
        check("bp_done_valid", b1.out_valid, 1'b0);
        check("bp_done_inst", b1.inst_o, NOP);

        b1.in_valid = 1; b1.inst_i = 32'h33; b1.hold_i = 1;
        tick();
        b1.in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", b1.out_valid, 1'b1);
            check("hold_inst", b1.inst_o, 32'h33);
            tick();
        end
        check("hold_still", b1.inst_o, 32'h33);
        b1.hold_i = 0;
        tick();
        check("hold_drained", b1.out_valid, 1'b0);

        b1.out_ready = 0;
        b1.in_valid = 1; b1.inst_i = 32'h44;
        tick();
        b1.inst_i = 32'h55;
        tick();
        check("fl_full", b1.skid_full_o, 1'b1);
        b1.inst_i = 32'hDD; b1.flush_i = 1;
        tick();
        b1.flush_i = 0; b1.in_valid = 0;
        check("fl_valid", b1.out_valid, 1'b0);
        check("fl_skid", b1.skid_full_o, 1'b0);
        check("fl_inst", b1.inst_o, NOP);
        check("fl_in_ready", b1.in_ready, 1'b1);
        b1.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_d", b1.out_valid, 1'b0);
        end

        b1.out_ready = 0;
        b1.in_valid = 1; b1.inst_i = 32'h66; b1.op1_i = 32'h77;
        tick();
        b1.inst_i = 32'h77;
        tick();
        b1.in_valid = 0;
        check("ar_pre_full", b1.skid_full_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("ar_valid", b1.out_valid, 1'b0);
        check("ar_inst", b1.inst_o, NOP);
        check("ar_op1", b1.op1_o, 32'h0);
        check("ar_skid", b1.skid_full_o, 1'b0);
        tick();
        #2 rst = 1'b1;
        tick();
        check("ar_after_valid", b1.out_valid, 1'b0);

        b0.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            b0.in_valid = 1; b0.inst_i = 32'h100 + i;
            #1;
            check("ns_in_ready", b0.in_ready, 1'b1);
            tick();
            check("ns_valid", b0.out_valid, 1'b1);
            check("ns_inst", b0.inst_o, 32'h100 + i);
        end
        b0.in_valid = 0; b0.out_ready = 0;
        #1;
        check("ns_backpressure", b0.in_ready, 1'b0);
        b0.out_ready = 1;
        #1;
        check("ns_drain_ready", b0.in_ready, 1'b1);
        tick();
        check("ns_empty_valid", b0.out_valid, 1'b0);
        check("ns_empty_inst", b0.inst_o, NOP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
